// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-look-ahead adder/subtractor: one BLOCK-bit CLA group per stage,
// group carries registered between stages, global stall via valid/ready.

module cla_pipe_group #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             ci,
   output logic [BLOCK-1:0] s,
   output logic             co,
   output logic             cm
);
   logic [BLOCK-1:0] g, p;
   logic [BLOCK:0]   cx;
   logic             t;

   assign g = a & b;
   assign p = a ^ b;

   // every carry is a flat sum of products of g/p/ci, not a ripple chain
   always_comb begin
      cx    = '0;
      cx[0] = ci;
      t     = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         t = ci;
         for (int k = 0; k <= i; k++) t = t & p[k];
         cx[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int k = j + 1; k <= i; k++) t = t & p[k];
            cx[i+1] = cx[i+1] | t;
         end
      end
   end

   assign s  = p ^ cx[BLOCK-1:0];
   assign co = cx[BLOCK];
   assign cm = cx[BLOCK-1];
endmodule

module cla_pipe_addsub #(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             v
);
   localparam int STAGES = WIDTH / BLOCK;

   generate
      if (WIDTH < 1 || BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
         $error("cla_pipe_addsub: WIDTH must be a positive multiple of BLOCK");
      end
   endgenerate

   logic [STAGES:1]                vld_pipe;
   logic [STAGES-1:0][WIDTH-1:0]   a_q, b_q, s_q;
   logic [STAGES-1:0][WIDTH-1:0]   a_d, b_d, s_d, s_n;
   logic [STAGES-1:0]              cy_q, ci_d, g_co, g_cm;
   logic [STAGES-1:0][BLOCK-1:0]   g_s;
   logic [WIDTH-1:0]               be;
   logic                           ce, adv, acc, v_q;
   logic                           unused_ok;

   assign be       = sub ? ~b : b;
   assign ce       = sub ? ~y : y;
   assign adv      = !out_valid || out_ready;
   assign in_ready = rst_n && adv;
   assign acc      = in_valid && in_ready;

   // stage k works on stage k-1's skewed operands and registered group carry
   always_comb begin
      a_d[0]  = a;
      b_d[0]  = be;
      ci_d[0] = ce;
      s_d[0]  = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_d[k]  = a_q[k-1];
         b_d[k]  = b_q[k-1];
         ci_d[k] = cy_q[k-1];
         s_d[k]  = s_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      cla_pipe_group #(.BLOCK(BLOCK)) u_grp (
         .a  (a_d[k][k*BLOCK +: BLOCK]),
         .b  (b_d[k][k*BLOCK +: BLOCK]),
         .ci (ci_d[k]),
         .s  (g_s[k]),
         .co (g_co[k]),
         .cm (g_cm[k])
      );
   end

   // finished lower slices ride along so the whole word leaves together
   always_comb begin
      s_n = s_d;
      for (int k = 0; k < STAGES; k++) s_n[k][k*BLOCK +: BLOCK] = g_s[k];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         cy_q     <= '0;
         v_q      <= 1'b0;
      end else if (adv) begin
         vld_pipe[1] <= acc;
         for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
         a_q  <= a_d;
         b_q  <= b_d;
         s_q  <= s_n;
         cy_q <= g_co;
         v_q  <= g_cm[STAGES-1] ^ g_co[STAGES-1];
      end
   end

   assign out_valid = vld_pipe[STAGES];
   assign s         = s_q[STAGES-1];
   assign c         = cy_q[STAGES-1];
   assign v         = v_q;

   // last-stage operand copies and inner carry-into-MSB taps are never consumed
   assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], g_cm};
endmodule
